// File: rtl/mpu_controller.sv
// Command sequencer for a 5x5 byte-matrix MPU: loads operands over a byte memory
// port, holds them on the datapath for a fixed time, then stores the result back.
module mpu_controller #(
    parameter logic [7:0]  A_BASE      = 8'd0,
    parameter logic [7:0]  B_BASE      = 8'd32,
    parameter logic [7:0]  R_BASE      = 8'd64,
    parameter int unsigned EXEC_CYCLES = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_opcode,
    input  logic [7:0]        cmd_size,
    input  logic signed [7:0] cmd_factor,
    output logic [7:0]        mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    output logic [2:0]        mpu_operation,
    output logic [199:0]      mpu_matrix_a,
    output logic [199:0]      mpu_matrix_b,
    output logic [7:0]        mpu_size,
    output logic [7:0]        mpu_factor,
    input  logic [199:0]      mpu_result,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned NELEM      = 25;
    localparam logic [7:0]  LOAD_LAST  = 8'd25;
    localparam logic [7:0]  STORE_LAST = 8'd24;
    localparam logic [7:0]  EXEC_LAST  = 8'(EXEC_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_STORE,
        S_DONE
    } state_t;

    state_t       state, state_nx;
    logic [7:0]   cnt, cnt_nx;
    logic [2:0]   op_q;
    logic [7:0]   size_q;
    logic [7:0]   factor_q;
    logic [199:0] a_q, b_q, res_q;
    logic         ready_q;
    logic         error_q;
    logic         accept;
    logic         cmd_ok;
    logic         op_binary;
    logic [7:0]   cap_idx;
    logic [7:0]   rd_base;
    logic [199:0] res_shift;

    // Element i lives in the i-th byte counted from the MSB end of the bus.
    function automatic logic [199:0] put_byte(input logic [199:0] m, input logic [7:0] idx,
                                              input logic [7:0] v);
        logic [199:0] r;
        r = m;
        for (int unsigned i = 0; i < NELEM; i++) begin
            if (idx == 8'(i)) r[199-8*i -: 8] = v;
        end
        return r;
    endfunction

    assign accept    = cmd_valid && ready_q && (state == S_IDLE);
    assign cmd_ok    = (cmd_opcode != 3'd5) && (cmd_opcode != 3'd7) &&
                       (cmd_size >= 8'd1) && (cmd_size <= 8'd5);
    assign op_binary = (op_q == 3'd0) || (op_q == 3'd1) || (op_q == 3'd6);
    assign cap_idx   = cnt - 8'd1;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    cnt_nx   = '0;
                    state_nx = cmd_ok ? S_LOAD_A : S_DONE;
                end
            end
            S_LOAD_A: begin
                if (cnt == LOAD_LAST) begin
                    cnt_nx   = '0;
                    state_nx = op_binary ? S_LOAD_B : S_EXEC;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            S_LOAD_B: begin
                if (cnt == LOAD_LAST) begin
                    cnt_nx   = '0;
                    state_nx = S_EXEC;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            S_EXEC: begin
                if (cnt == EXEC_LAST) begin
                    cnt_nx   = '0;
                    state_nx = S_STORE;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            S_STORE: begin
                if (cnt == STORE_LAST) begin
                    cnt_nx   = '0;
                    state_nx = S_DONE;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            S_DONE: begin
                cnt_nx   = '0;
                state_nx = S_IDLE;
            end
            default: begin
                cnt_nx   = '0;
                state_nx = S_IDLE;
            end
        endcase
    end

    // Load states issue on counts 0..24; count 25 only captures the last byte.
    always_comb begin
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        rd_base     = (state == S_LOAD_B) ? B_BASE : A_BASE;
        res_shift   = res_q << {cnt, 3'b000};
        if (((state == S_LOAD_A) || (state == S_LOAD_B)) && (cnt != LOAD_LAST)) begin
            mem_rd_en = 1'b1;
            mem_addr  = rd_base + cnt;
        end else if (state == S_STORE) begin
            mem_wr_en   = 1'b1;
            mem_addr    = R_BASE + cnt;
            mem_wr_data = res_shift[199:192];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
            op_q     <= '0;
            size_q   <= '0;
            factor_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ready_q <= (state_nx == S_IDLE);
            if (accept) begin
                op_q     <= cmd_opcode;
                size_q   <= cmd_size;
                factor_q <= cmd_factor;
                error_q  <= !cmd_ok;
            end
            if ((state == S_LOAD_A) && (cnt != 8'd0)) a_q <= put_byte(a_q, cap_idx, mem_rd_data);
            if ((state == S_LOAD_B) && (cnt != 8'd0)) b_q <= put_byte(b_q, cap_idx, mem_rd_data);
            if ((state == S_EXEC) && (cnt == EXEC_LAST)) res_q <= mpu_result;
        end
    end

    assign cmd_ready     = ready_q;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign error         = error_q;
    assign mpu_operation = op_q;
    assign mpu_size      = size_q;
    assign mpu_factor    = factor_q;
    assign mpu_matrix_a  = a_q;
    assign mpu_matrix_b  = b_q;

endmodule

// File: doc/mpu_controller.md
MPU_CONTROLLER -- requirements
Module: mpu_controller

Interface
REQ-001 SHALL have parameter A_BASE, default 8'd0, byte address of matrix A in memory.
REQ-002 SHALL have parameter B_BASE, default 8'd32, byte address of matrix B.
REQ-003 SHALL have parameter R_BASE, default 8'd64, byte address of the result matrix.
REQ-004 SHALL have parameter EXEC_CYCLES, default 8, number of cycles operands are held before the result is sampled (range 1..255).
REQ-005 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1), cmd_opcode (input, 3), cmd_size (input, 8), cmd_factor (input, 8, signed): command handshake.
REQ-008 SHALL have ports mem_addr (output, 8), mem_rd_en (output, 1), mem_rd_data (input, 8), mem_wr_en (output, 1), mem_wr_data (output, 8): byte memory port with 1-cycle read latency.
REQ-009 SHALL have ports mpu_operation (output, 3), mpu_matrix_a (output, 200), mpu_matrix_b (output, 200), mpu_size (output, 8), mpu_factor (output, 8): operand drive to the MPU datapath.
REQ-010 SHALL have port mpu_result, input, 200, datapath result.
REQ-011 SHALL have ports busy (output, 1), done (output, 1), error (output, 1).

Function
REQ-012 SHALL implement states IDLE, LOAD_A, LOAD_B, EXEC, STORE, DONE.
REQ-013 SHALL assert cmd_ready only in IDLE; the command is accepted on a cycle with cmd_valid && cmd_ready, latching opcode, size and factor.
REQ-014 SHALL treat opcodes 0 (add), 1 (sub) and 6 (mul) as binary, 2 (imul), 3 (opposite) and 4 (transpose) as unary, and 5 and 7 as invalid.
REQ-015 SHALL treat cmd_size outside 1..5 as invalid.
REQ-016 SHALL, on an invalid command, go IDLE -> DONE with error=1 and perform no memory access.
REQ-017 SHALL, on a valid command, go IDLE -> LOAD_A.
REQ-018 SHALL, in LOAD_A, issue reads at A_BASE+0..A_BASE+24, one per cycle, and store the byte returned for address offset i as element i.
REQ-019 SHALL place element i (row-major, 0..24) in the i-th byte counted from the MSB end of the 200-bit bus.
REQ-020 SHALL make LOAD_A last exactly 26 cycles: 25 issue cycles plus 1 cycle to capture the last byte.
REQ-021 SHALL leave LOAD_A for LOAD_B (binary opcodes) or EXEC (unary opcodes).
REQ-022 SHALL make LOAD_B identical to LOAD_A but use B_BASE; for unary opcodes mpu_matrix_b keeps its previous value.
REQ-023 SHALL, in EXEC, hold mpu_operation, mpu_size, mpu_factor and both matrices stable for EXEC_CYCLES cycles, sample mpu_result on the last EXEC cycle, then enter STORE.
REQ-024 SHALL, in STORE, write result element i to R_BASE+i over 25 consecutive cycles with mem_wr_en=1, then enter DONE.
REQ-025 SHALL never assert mem_rd_en and mem_wr_en in the same cycle.
REQ-026 SHALL hold mem_addr at 0 whenever neither mem_rd_en nor mem_wr_en is asserted.
REQ-027 SHALL stay in DONE for exactly 1 cycle with done=1, then return to IDLE.
REQ-028 SHALL hold error, which is set only on rejection, until the next accepted command.
REQ-029 SHALL assert busy in every state except IDLE.
REQ-030 SHALL ignore cmd_valid while busy and shall not queue commands.
REQ-031 SHALL perform address arithmetic modulo 256 (wrap-around).
REQ-032 SHALL drive mpu_operation and the other mpu_* outputs from registers only.

Reset
REQ-033 SHALL, while reset_n=0, immediately force state IDLE, and shall clear all outputs and internal buffers, counters, opcode, size and factor to 0; cmd_ready becomes 1 on the first rising edge after reset_n rises.
REQ-034 SHALL, on reset asserted in any state, abort the operation with no further memory writes; a partial STORE is not completed or rolled back.

Verification
REQ-035 SHALL cover add: A elements = 1..25, B all 2, opcode 0, size 5 -> 26+26+8+25 cycles after accept, memory R_BASE..R_BASE+24 = 3..27, done pulses 1 cycle, error=0.
REQ-036 SHALL cover a unary op: opcode 3, A all 5 -> no reads at B_BASE, R region = -5 (8'hFB), total 26+8+25 cycles to DONE.
REQ-037 SHALL cover invalid commands: opcode 5, then opcode 0 with size 0 -> each gives DONE on the 2nd cycle after accept with error=1 and zero memory accesses.
REQ-038 SHALL cover busy rejection: cmd_valid held high throughout an add -> exactly one command is executed, and cmd_ready=0 from the accept cycle+1 until after DONE.
REQ-039 SHALL cover reset mid-STORE: reset_n pulsed low on the 10th write -> mem_wr_en drops immediately, all outputs read 0, and the next command executes correctly.
REQ-040 SHALL cover mul with EXEC_CYCLES=8, where the datapath model presents its product on cycle 7 -> the product is stored, and a model stall beyond 8 cycles is flagged as a bench failure.
